serial_rx: RTL
==============

SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, CLK cycles per serial bit; even, 4..1024.
REQ-002 Parameter: FIFO_DEPTH, default 4, receive buffer entries; fixed power of two.
REQ-003 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: CLR  input  1  synchronous, active-high reset.
REQ-005 Port: SERIAL_IN  input  1  asynchronous serial line from the CPU SERIAL_OUT; idles high.
REQ-006 Port: RX_RD  input  1  pop request for the FIFO head.
REQ-007 Port: RX_DATA  output  8  FIFO head byte; valid only while RX_VALID=1.
REQ-008 Port: RX_VALID  output  1  FIFO non-empty.
REQ-009 Port: FRAME_ERR  output  1  one-cycle pulse on a bad stop bit.
REQ-010 Port: OVERRUN  output  1  sticky; a completed byte arrived while the FIFO was full.
REQ-011 Port: BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-013 SERIAL_IN SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the synchronized value (rx_s).
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, WAIT_HIGH; the bit-period counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide.
REQ-015 IDLE: rx_s=0 -> START with counter cleared.
REQ-016 START: when counter reaches CLKS_PER_BIT/2-1, resample rx_s: 0 -> DATA with counter cleared and bit index 0; 1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: when counter reaches CLKS_PER_BIT-1, shift rx_s into bit[index] and clear counter; after index 7 -> STOP.
REQ-018 STOP: when counter reaches CLKS_PER_BIT-1, sample rx_s: 1 -> push byte and go to IDLE; 0 -> FRAME_ERR=1 for exactly one cycle, discard byte, go to WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rx_s=1, then go to IDLE; a held-low line (break) SHALL produce exactly one FRAME_ERR.
REQ-020 FIFO: RX_DATA SHALL show the oldest unread byte; RX_VALID=1 iff occupancy>0; occupancy counter width log2(FIFO_DEPTH)+1.
REQ-021 A pop SHALL occur when RX_RD=1 and RX_VALID=1; RX_RD while empty SHALL be ignored.
REQ-022 Push while full without a simultaneous pop: byte dropped, FIFO contents unchanged, OVERRUN set to 1.
REQ-023 Simultaneous push and pop SHALL both take effect in the same cycle (occupancy unchanged), including when full (no overrun).
REQ-024 OVERRUN SHALL clear only on CLR.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 Pushed byte SHALL be visible on RX_DATA/RX_VALID the cycle after the stop-bit sample.

Reset
REQ-027 CLR=1 at a clock edge SHALL force: FSM=IDLE, counters=0, synchronizer flops=1, FIFO empty, RX_VALID=0, RX_DATA=8'h00, FRAME_ERR=0, OVERRUN=0, BUSY=0.
REQ-028 CLR asserted mid-frame SHALL abandon the frame; no partial byte SHALL be pushed; the next start bit after CLR deasserts SHALL be received normally.
REQ-029 With CLR=1, SERIAL_IN, and RX_RD SHALL be ignored.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-030 Send 0xA5, well-formed -> RX_VALID rises within 2+8+9*16+2 cycles of the start edge, RX_DATA=0xA5, FRAME_ERR never 1; RX_RD pulse -> RX_VALID=0.
REQ-031 Start bit low for 4 cycles, then high -> BUSY pulses, FSM back in IDLE, RX_VALID stays 0, no FRAME_ERR.
REQ-032 Send 0x3C with stop bit 0, then hold line low for 40 cycles -> exactly one FRAME_ERR pulse, no push; next good frame 0x81 -> RX_DATA=0x81.
REQ-033 Send 0x01..0x05 without reads -> RX_DATA=0x01, OVERRUN=1 after the 5th; four pops read 0x01,0x02,0x03,0x04, then RX_VALID=0.
REQ-034 FIFO full, RX_RD=1 in the push cycle of 0x55 -> OVERRUN stays 0, pops return the remaining three bytes then 0x55.
REQ-035 CLR pulsed during data bit 4 of 0xF0 -> no push, all outputs at reset values; following frame 0x0F -> RX_DATA=0x0F.

Source files
------------

// File: rtl/serial_rx.sv
// UART-style receiver: 2-flop synchronizer, mid-bit sampling FSM and a small receive FIFO.
// Bad stop bits pulse FRAME_ERR once; a completed byte arriving while the FIFO is full sets sticky OVERRUN.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       SERIAL_IN,
  input  logic       RX_RD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] DEPTH   = OW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync1_d;
  logic            rx_s_q, rx_s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   count_q, count_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            push, pop, full, wr_en;

  always_comb begin
    sync1_d     = SERIAL_IN;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    pop       = RX_RD && (count_q != '0);
    full      = (count_q == DEPTH);
    wr_en     = push && (!full || pop);
    overrun_d = overrun_q | (push && full && !pop);
    wr_ptr_d  = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!CLR && wr_en) mem[wr_ptr_q] <= shift_q;
  end

  assign RX_VALID  = (count_q != '0);
  assign RX_DATA   = RX_VALID ? mem[rd_ptr_q] : '0;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
  assign BUSY      = (state_q != IDLE);

endmodule
